// File: rtl/shift_pkg.sv
// Opcode encodings, decoded-op struct and decoder for the shift execute stage.
// ASR decoding exists only when SHIFT_EXEC_ASR_EN is defined.
package shift_pkg;

   localparam int TAG_W = 5;

   localparam logic [2:0] OP_SHL = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_ROL = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ASR = 3'b100;

   typedef struct packed {
      logic dir_right;
      logic is_rotate;
      logic is_arith;
      logic illegal;
   } dec_t;

   function automatic dec_t decode_op(input logic [2:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_SHL: d.illegal = 1'b0;
         OP_SHR: d.dir_right = 1'b1;
         OP_ROL: d.is_rotate = 1'b1;
         OP_ROR: begin
            d.dir_right = 1'b1;
            d.is_rotate = 1'b1;
         end
`ifdef SHIFT_EXEC_ASR_EN
         OP_ASR: begin
            d.dir_right = 1'b1;
            d.is_arith  = 1'b1;
         end
`endif
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational left shift/rotate with a fill bit for vacated positions and a
// carry output holding the last bit pushed past the top of the word.
module shift_core
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AMT_W-1:0] amt_i,
   input  logic             rotate_i,
   input  logic             fill_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   localparam int LOG_W = $clog2(WIDTH);

   logic [WIDTH:0]     shlWide;
   logic [2*WIDTH-1:0] rotWide;
   logic [WIDTH-1:0]   fillMask;
   logic [WIDTH-1:0]   rotResult;
   logic [LOG_W-1:0]   rotAmt;

   // Shifts of WIDTH or more leave only fill; the extra top bit of shlWide
   // catches the outgoing bit for amounts 1..WIDTH.
   always_comb begin
      shlWide   = {1'b0, data_i} << amt_i;
      fillMask  = ~({WIDTH{1'b1}} << amt_i);
      rotAmt    = amt_i[LOG_W-1:0];
      rotWide   = {data_i, data_i} << rotAmt;
      rotResult = rotWide[2*WIDTH-1:WIDTH];
      if (rotate_i) begin
         result_o = rotResult;
         carry_o  = (rotAmt != '0) && rotResult[0];
      end else begin
         result_o = shlWide[WIDTH-1:0] | (fill_i ? fillMask : '0);
         if (amt_i == '0)
            carry_o = 1'b0;
         else if (amt_i > AMT_W'(WIDTH))
            carry_o = fill_i;
         else
            carry_o = shlWide[WIDTH];
      end
   end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift/rotate execute front end with valid/ready on both sides.
// Define SHIFT_EXEC_ASR_EN to enable arithmetic shift right (opcode 100).
module shift_exec_stage
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic             s1_valid_q, s1_valid_d;
   dec_t             s1_dec_q, s1_dec_d;
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [AMT_W-1:0] s1_amt_q, s1_amt_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q, s2_data_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_illegal_q, s2_illegal_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic             s2Adv, s1Adv, accept;
   logic [WIDTH-1:0] coreIn, coreOut, shifted, result;
   logic             coreFill, coreCarry, s1Illegal;

   always_comb begin
      s2Adv    = !s2_valid_q || out_ready;
      s1Adv    = s1_valid_q && s2Adv;
      in_ready = !s1_valid_q || s2Adv;
      accept   = in_valid && in_ready;
   end

`ifdef SHIFT_EXEC_ASR_EN
   always_comb begin
      coreFill  = s1_dec_q.is_arith & s1_data_q[WIDTH-1];
      s1Illegal = s1_dec_q.illegal;
   end
`else
   // Without sign-fill hardware an arithmetic op cannot be executed, so it is
   // folded into the illegal flag (the decoder never raises it in this build).
   always_comb begin
      coreFill  = 1'b0;
      s1Illegal = s1_dec_q.illegal | s1_dec_q.is_arith;
   end
`endif

   // Right-direction ops run through the left-only core bit-reversed.
   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         coreIn[i] = s1_dec_q.dir_right ? s1_data_q[WIDTH-1-i] : s1_data_q[i];
   end

   shift_core #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_core (
      .data_i   (coreIn),
      .amt_i    (s1_amt_q),
      .rotate_i (s1_dec_q.is_rotate),
      .fill_i   (coreFill),
      .result_o (coreOut),
      .carry_o  (coreCarry)
   );

   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         shifted[i] = s1_dec_q.dir_right ? coreOut[WIDTH-1-i] : coreOut[i];
      result = s1Illegal ? s1_data_q : shifted;
   end

   // Flush wins over both accept and advance; data fields only move on a
   // transfer so stalled stages hold their contents.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_dec_d     = s1_dec_q;
      s1_data_d    = s1_data_q;
      s1_amt_d     = s1_amt_q;
      s1_tag_d     = s1_tag_q;
      s2_valid_d   = s2_valid_q;
      s2_data_d    = s2_data_q;
      s2_carry_d   = s2_carry_q;
      s2_zero_d    = s2_zero_q;
      s2_illegal_d = s2_illegal_q;
      s2_tag_d     = s2_tag_q;

      if (accept) begin
         s1_dec_d  = decode_op(in_op);
         s1_data_d = in_data;
         s1_amt_d  = in_amt;
         s1_tag_d  = in_tag;
      end
      if (flush)       s1_valid_d = 1'b0;
      else if (accept) s1_valid_d = 1'b1;
      else if (s1Adv)  s1_valid_d = 1'b0;

      if (s1Adv) begin
         s2_data_d    = result;
         s2_carry_d   = s1Illegal ? 1'b0 : coreCarry;
         s2_zero_d    = (result == '0);
         s2_illegal_d = s1Illegal;
         s2_tag_d     = s1_tag_q;
      end
      if (flush)      s2_valid_d = 1'b0;
      else if (s1Adv) s2_valid_d = 1'b1;
      else if (s2Adv) s2_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_dec_q     <= '0;
         s1_data_q    <= '0;
         s1_amt_q     <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= '0;
         s2_carry_q   <= 1'b0;
         s2_zero_q    <= 1'b0;
         s2_illegal_q <= 1'b0;
         s2_tag_q     <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_dec_q     <= s1_dec_d;
         s1_data_q    <= s1_data_d;
         s1_amt_q     <= s1_amt_d;
         s1_tag_q     <= s1_tag_d;
         s2_valid_q   <= s2_valid_d;
         s2_data_q    <= s2_data_d;
         s2_carry_q   <= s2_carry_d;
         s2_zero_q    <= s2_zero_d;
         s2_illegal_q <= s2_illegal_d;
         s2_tag_q     <= s2_tag_d;
      end
   end

   always_comb begin
      out_valid   = s2_valid_q;
      out_data    = s2_data_q;
      out_carry   = s2_carry_q;
      out_zero    = s2_zero_q;
      out_illegal = s2_illegal_q;
      out_tag     = s2_tag_q;
   end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage at WIDTH=8, AMT_W=4.
// Expectations for opcode 100 follow whether SHIFT_EXEC_ASR_EN is defined.
module tb_shift_exec_stage;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [W-1:0]  in_data = '0;
   logic [AW-1:0] in_amt = '0;
   logic [4:0]    in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic          out_carry;
   logic          out_zero;
   logic          out_illegal;
   logic [4:0]    out_tag;

   int total = 0;
   int bad   = 0;

   shift_exec_stage #(
      .WIDTH (W),
      .AMT_W (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_data     (in_data),
      .in_amt      (in_amt),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_carry   (out_carry),
      .out_zero    (out_zero),
      .out_illegal (out_illegal),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   task automatic present(input logic [2:0] op, input logic [W-1:0] d,
                          input logic [AW-1:0] a, input logic [4:0] t);
      in_op    = op;
      in_data  = d;
      in_amt   = a;
      in_tag   = t;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", out_data); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL reset_carry got=%b want=0", out_carry); end
      total++; if (out_zero !== 1'b0) begin bad++; $display("[TB] FAIL reset_zero got=%b want=0", out_zero); end
      total++; if (out_illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal got=%b want=0", out_illegal); end
      total++; if (out_tag !== 5'd0) begin bad++; $display("[TB] FAIL reset_tag got=%0d want=0", out_tag); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_latency();
      @(posedge clk); #1;
      out_ready = 1'b1;
      present(3'b000, 8'h81, 4'd1, 5'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lat_early_valid got=%b want=0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lat_valid got=%b want=1", out_valid); end
      total++; if (out_data !== 8'h02) begin bad++; $display("[TB] FAIL lat_data got=%h want=02", out_data); end
      total++; if (out_carry !== 1'b1) begin bad++; $display("[TB] FAIL lat_carry got=%b want=1", out_carry); end
      total++; if (out_zero !== 1'b0) begin bad++; $display("[TB] FAIL lat_zero got=%b want=0", out_zero); end
      total++; if (out_tag !== 5'd3) begin bad++; $display("[TB] FAIL lat_tag got=%0d want=3", out_tag); end
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
`ifdef SHIFT_EXEC_ASR_EN
      localparam logic ASR_ILL = 1'b0;
      localparam logic [W-1:0] ASR_80_3 = 8'hF0, ASR_90_8 = 8'hFF, ASR_7F_9 = 8'h00;
      localparam logic ASR_90_8_C = 1'b1;
`else
      localparam logic ASR_ILL = 1'b1;
      localparam logic [W-1:0] ASR_80_3 = 8'h80, ASR_90_8 = 8'h90, ASR_7F_9 = 8'h7F;
      localparam logic ASR_90_8_C = 1'b0;
`endif
      logic [2:0]    vop [16];
      logic [W-1:0]  vdat [16];
      logic [AW-1:0] vamt [16];
      logic [W-1:0]  xdat [16];
      logic          xcar [16];
      logic          xill [16];
      logic [W-1:0]  expData;
      vop  = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd7, 3'd1, 3'd2,
               3'd0, 3'd2, 3'd4, 3'd0, 3'd3, 3'd1, 3'd4, 3'd5};
      vdat = '{8'h01, 8'hA5, 8'hFF, 8'hFF, 8'h80, 8'h3C, 8'h81, 8'h81,
               8'h01, 8'h80, 8'h90, 8'hB1, 8'h06, 8'h80, 8'h7F, 8'h00};
      vamt = '{4'd9, 4'd0, 4'd8, 4'd9, 4'd3, 4'd2, 4'd1, 4'd1,
               4'd8, 4'd8, 4'd8, 4'd3, 4'd2, 4'd15, 4'd9, 4'd1};
      xdat = '{8'h80, 8'hA5, 8'h00, 8'h00, ASR_80_3, 8'h3C, 8'h40, 8'h03,
               8'h00, 8'h80, ASR_90_8, 8'h88, 8'h81, 8'h00, ASR_7F_9, 8'h00};
      xcar = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b1, 1'b0, ASR_90_8_C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      xill = '{1'b0, 1'b0, 1'b0, 1'b0, ASR_ILL, 1'b1, 1'b0, 1'b0,
               1'b0, 1'b0, ASR_ILL, 1'b0, 1'b0, 1'b0, ASR_ILL, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         present(vop[i], vdat[i], vamt[i], 5'(i));
         @(posedge clk); #1;
         in_valid = 1'b0;
         for (int c = 0; c < 6 && !out_valid; c++) begin
            @(posedge clk); #1;
         end
         expData = xdat[i];
         total++;
         if (out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL vec%0d_timeout got=%b want=1", i, out_valid);
         end else begin
            if (out_data !== expData) begin bad++; $display("[TB] FAIL vec%0d_data got=%h want=%h", i, out_data, expData); end
            total++; if (out_carry !== xcar[i]) begin bad++; $display("[TB] FAIL vec%0d_carry got=%b want=%b", i, out_carry, xcar[i]); end
            total++; if (out_zero !== (expData == '0)) begin bad++; $display("[TB] FAIL vec%0d_zero got=%b want=%b", i, out_zero, expData == '0); end
            total++; if (out_illegal !== xill[i]) begin bad++; $display("[TB] FAIL vec%0d_illegal got=%b want=%b", i, out_illegal, xill[i]); end
            total++; if (out_tag !== 5'(i)) begin bad++; $display("[TB] FAIL vec%0d_tag got=%0d want=%0d", i, out_tag, i); end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] expData;
      int  sent = 0;
      int  rcv = 0;
      int  seen = 0;
      bit  stallSeen = 0;
      for (int c = 0; c < 40 && rcv < 4; c++) begin
         @(posedge clk); #1;
         out_ready = (c >= 3);
         if (sent < 4) present(3'b000, 8'h01, 4'(sent + 1), 5'(10 + sent));
         else in_valid = 1'b0;
         #1;
         if (out_valid && out_ready) begin
            expData = 8'h01 << (rcv + 1);
            total++; if (out_data !== expData) begin bad++; $display("[TB] FAIL b2b_data%0d got=%h want=%h", rcv, out_data, expData); end
            total++; if (out_tag !== 5'(10 + rcv)) begin bad++; $display("[TB] FAIL b2b_tag%0d got=%0d want=%0d", rcv, out_tag, 10 + rcv); end
            rcv++;
         end
         if (in_valid && !in_ready && !stallSeen) begin
            stallSeen = 1;
            total++; if (sent !== 2) begin bad++; $display("[TB] FAIL b2b_stall_point got=%0d want=2", sent); end
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      total++; if (!stallSeen) begin bad++; $display("[TB] FAIL b2b_no_stall got=0 want=1"); end
      total++; if (rcv !== 4) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=4", rcv); end
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("[TB] FAIL b2b_extra got=%0d want=0", seen); end
   endtask

   task automatic test_flush();
      int seen = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      present(3'b000, 8'h11, 4'd1, 5'd20);
      @(posedge clk); #1;
      present(3'b000, 8'h22, 4'd1, 5'd21);
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_prefill got=%b want=1", out_valid); end
      present(3'b000, 8'h33, 4'd1, 5'd22);
      out_ready = 1'b1;
      flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready got=%b want=1", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_next got=%b want=0", out_valid); end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("[TB] FAIL flush_leak got=%0d want=0", seen); end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      present(3'b000, 8'h8F, 4'd1, 5'd7);
      @(posedge clk); #1;
      present(3'b010, 8'h01, 4'd1, 5'd8);
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_data !== 8'h1E) begin bad++; $display("[TB] FAIL rstmid_pre_data got=%h want=1e", out_data); end
      total++; if (out_carry !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_pre_carry got=%b want=1", out_carry); end
      #2 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data got=%h want=00", out_data); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_carry got=%b want=0", out_carry); end
      total++; if (out_tag !== 5'd0) begin bad++; $display("[TB] FAIL rstmid_tag got=%0d want=0", out_tag); end
      @(posedge clk); #3;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rstmid_leak got=%0d want=0", seen); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_vectors();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
